// File: rtl/adder_result_display.sv
// Captures the 5-bit adder result and scans it onto a 4-digit common-anode 7-segment display:
// digits 3:2 in hex, digits 1:0 in decimal. Define LEADING_ZERO_BLANK_EN to blank the leading zeros.
module adder_result_display #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] sum,
   input  logic       cout,
   output logic [4:0] value,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int             CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]  CNT_MAX   = CW'(REFRESH_DIV - 1);
   localparam logic [6:0]     SEG_BLANK = 7'h7F;

   logic [4:0]    value_q, value_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic          cntWrap;
   logic [1:0]    tensDigit;
   logic [3:0]    onesDigit;
   logic [3:0]    tensOffset;

   function automatic logic [6:0] hexSeg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Capture, refresh counter and digit index advance.
   always_comb begin
      value_d = in_valid ? {cout, sum} : value_q;
      cntWrap = (cnt_q == CNT_MAX);
      cnt_d   = cntWrap ? '0 : cnt_q + 1'b1;
      idx_d   = cntWrap ? idx_q + 2'd1 : idx_q;
   end

   // Decimal split of 0..31. The ones digit is always below 10, so subtracting the
   // low nibble of tens*10 (0, 10, 20, 30 -> 0, A, 4, E) in 4-bit arithmetic is exact.
   always_comb begin
      tensDigit  = 2'd0;
      tensOffset = 4'd0;
      if (value_q >= 5'd30) begin
         tensDigit  = 2'd3;
         tensOffset = 4'd14;
      end else if (value_q >= 5'd20) begin
         tensDigit  = 2'd2;
         tensOffset = 4'd4;
      end else if (value_q >= 5'd10) begin
         tensDigit  = 2'd1;
         tensOffset = 4'd10;
      end
      onesDigit = value_q[3:0] - tensOffset;
   end

   // Segment pattern for the digit currently selected by idx_q.
   always_comb begin
      seg_d = SEG_BLANK;
      an_d  = ~(4'b0001 << idx_q);
      case (idx_q)
         2'd0: seg_d = hexSeg(onesDigit);
         2'd1: begin
            seg_d = hexSeg({2'b00, tensDigit});
`ifdef LEADING_ZERO_BLANK_EN
            if (tensDigit == 2'd0) seg_d = SEG_BLANK;
`endif
         end
         2'd2: seg_d = hexSeg(value_q[3:0]);
         default: begin
            seg_d = hexSeg({3'b000, value_q[4]});
`ifdef LEADING_ZERO_BLANK_EN
            if (!value_q[4]) seg_d = SEG_BLANK;
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_BLANK;
         an_q    <= 4'b1111;
      end else begin
         value_q <= value_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign value = value_q;
   assign seg   = seg_q;
   assign an    = an_q;
   assign dp    = 1'b1;

endmodule

// File: tb/tb_adder_result_display.sv
// Directed self-checking bench for adder_result_display with REFRESH_DIV=4.
// Expectations follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_adder_result_display;

   localparam int DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] sum;
   logic       cout;
   logic [4:0] value;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   int assertCount = 0;
   int failCount   = 0;

   adder_result_display #(.REFRESH_DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .sum      (sum),
      .cout     (cout),
      .value    (value),
      .seg      (seg),
      .an       (an),
      .dp       (dp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Steps the clock until the given anode pattern appears, bounded to a little over one scan.
   task automatic waitAn(input logic [3:0] target, output bit found);
      int n;
      found = 1'b0;
      n = 0;
      while (!found && n < 4 * DIV + 4) begin
         tick();
         n++;
         if (an === target) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; sum = 4'h0; cout = 1'b0;
      tick();
      tick();
      assertCount++;
      if (an !== 4'b1111) begin failCount++; $display("[TB] FAIL reset_an: got %b expected %b", an, 4'b1111); end
      assertCount++;
      if (seg !== 7'h7F) begin failCount++; $display("[TB] FAIL reset_seg: got %h expected %h", seg, 7'h7F); end
      assertCount++;
      if (value !== 5'd0) begin failCount++; $display("[TB] FAIL reset_value: got %0d expected 0", value); end
      assertCount++;
      if (dp !== 1'b1) begin failCount++; $display("[TB] FAIL reset_dp: got %b expected 1", dp); end
      rst = 1'b0;
      for (int i = 0; i < DIV; i++) begin
         tick();
         assertCount++;
         if (an !== 4'b1110 || seg !== 7'h40) begin
            failCount++;
            $display("[TB] FAIL release_digit0 cycle %0d: got an=%b seg=%h expected an=1110 seg=40", i, an, seg);
         end
      end
      tick();
      assertCount++;
      if (an !== 4'b1101 || seg !== LZ) begin
         failCount++;
         $display("[TB] FAIL release_digit1: got an=%b seg=%h expected an=1101 seg=%h", an, seg, LZ);
      end
   endtask

   task automatic test_scan_31();
      logic [3:0] anTab [4];
      logic [6:0] segTab [4];
      bit found;
      anTab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      segTab = '{7'h79, 7'h30, 7'h0E, 7'h79};
      sum = 4'hF; cout = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      assertCount++;
      if (value !== 5'd31) begin failCount++; $display("[TB] FAIL capture_31: got %0d expected 31", value); end
      for (int d = 0; d < 4; d++) begin
         waitAn(anTab[d], found);
         assertCount++;
         if (!found || seg !== segTab[d]) begin
            failCount++;
            $display("[TB] FAIL scan31_idx%0d: got found=%0d an=%b seg=%h expected an=%b seg=%h",
                     d, found, an, seg, anTab[d], segTab[d]);
         end
      end
   endtask

   task automatic test_value_9();
      logic [3:0] anTab [4];
      logic [6:0] segTab [4];
      bit found;
      anTab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      segTab = '{7'h10, LZ, 7'h10, LZ};
      sum = 4'h9; cout = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      assertCount++;
      if (value !== 5'd9) begin failCount++; $display("[TB] FAIL capture_9: got %0d expected 9", value); end
      for (int d = 0; d < 4; d++) begin
         waitAn(anTab[d], found);
         assertCount++;
         if (!found || seg !== segTab[d]) begin
            failCount++;
            $display("[TB] FAIL scan9_idx%0d: got found=%0d an=%b seg=%h expected an=%b seg=%h",
                     d, found, an, seg, anTab[d], segTab[d]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int hits;
      sum = 4'd5; cout = 1'b0; in_valid = 1'b1;
      tick();
      assertCount++;
      if (value !== 5'd5) begin failCount++; $display("[TB] FAIL b2b_first: got %0d expected 5", value); end
      sum = 4'd12;
      tick();
      in_valid = 1'b0;
      assertCount++;
      if (value !== 5'd12) begin failCount++; $display("[TB] FAIL b2b_second: got %0d expected 12", value); end
      hits = 0;
      for (int i = 0; i < 4 * DIV; i++) begin
         tick();
         if (an === 4'b1110) begin
            hits++;
            assertCount++;
            if (seg !== 7'h24) begin failCount++; $display("[TB] FAIL b2b_idx0 cycle %0d: got %h expected 24", i, seg); end
         end else if (an === 4'b1011) begin
            hits++;
            assertCount++;
            if (seg !== 7'h46) begin failCount++; $display("[TB] FAIL b2b_idx2 cycle %0d: got %h expected 46", i, seg); end
         end
      end
      assertCount++;
      if (hits != 2 * DIV) begin failCount++; $display("[TB] FAIL b2b_slots: got %0d expected %0d", hits, 2 * DIV); end
   endtask

   task automatic test_wrap_capture();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      sum = 4'h6; cout = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      assertCount++;
      if (value !== 5'd22 || an !== 4'b1110 || seg !== 7'h40) begin
         failCount++;
         $display("[TB] FAIL wrap_edge: got value=%0d an=%b seg=%h expected value=22 an=1110 seg=40", value, an, seg);
      end
      tick();
      assertCount++;
      if (an !== 4'b1101 || seg !== 7'h24) begin
         failCount++;
         $display("[TB] FAIL wrap_next: got an=%b seg=%h expected an=1101 seg=24", an, seg);
      end
   endtask

   task automatic test_reset_mid_scan();
      tick();
      tick();
      rst = 1'b1; in_valid = 1'b1; sum = 4'h3; cout = 1'b0;
      tick();
      assertCount++;
      if (an !== 4'b1111 || seg !== 7'h7F || value !== 5'd0) begin
         failCount++;
         $display("[TB] FAIL midscan_reset: got an=%b seg=%h value=%0d expected an=1111 seg=7f value=0", an, seg, value);
      end
      rst = 1'b0; in_valid = 1'b0;
      tick();
      assertCount++;
      if (an !== 4'b1110 || seg !== 7'h40 || value !== 5'd0) begin
         failCount++;
         $display("[TB] FAIL midscan_release: got an=%b seg=%h value=%0d expected an=1110 seg=40 value=0", an, seg, value);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; sum = 4'h0; cout = 1'b0;
      test_reset();
      test_scan_31();
      test_value_9();
      test_back_to_back();
      test_wrap_capture();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
